sr_share_ctrl: RTL and testbench
================================

// Module: sr_share_ctrl
// PURPOSE
//  Shares one WIDTH-bit serial-out shift register between two requesters.
//  Round-robin arbitration picks a requester, loads its parallel word, shifts it out serially, then pulses done.
//  Sits in front of the serial link; requesters present parallel words and never drive the shift register directly.
// PARAMETERS
//  WIDTH    5   bits per transfer and shift-register length (>=2)
//  MSB_1ST  0   0: shift right, LSB out first; 1: shift left, MSB out first
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-high reset
//  req       in   2      req[i]=1: requester i has a word pending (level)
//  data0     in   WIDTH  parallel word of requester 0
//  data1     in   WIDTH  parallel word of requester 1
//  gnt       out  2      one-hot grant, held for the whole transfer
//  busy      out  1      1 while in SHIFT or DONE
//  SO        out  1      serial output bit
//  so_valid  out  1      1 while SO carries a payload bit
//  done      out  1      one-cycle pulse after the last bit
//  done_id   out  1      requester that finished; valid only when done=1
// BEHAVIOUR
//  - rst: everything is asynchronous; rst=1 takes effect immediately and holds while asserted.
//  - Reset values: state=IDLE, SR=0, count=0, last=1.
//  - All outputs are 0 in reset, including gnt=2'b00.
//  - FSM states: IDLE, SHIFT, DONE. Every transition happens on a clk edge.
//  - IDLE, req==0:
//    - Stay in IDLE. gnt=0, so_valid=0, SO=0.
//  - IDLE, req!=0: arbitrate.
//    - Only one bit set: that requester wins.
//    - Both bits set: winner = ~last, so requester 0 wins first after reset.
//    - At the edge: SR <= winner's data, gnt <= onehot(winner), count <= WIDTH-1, state <= SHIFT.
//    - Data is sampled only at this grant edge.
//  - SHIFT:
//    - so_valid=1.
//    - SO = SR[0] when MSB_1ST=0, else SR[WIDTH-1].
//    - Each edge shifts SR one place with 0 fill: {1'b0,SR[W-1:1]} or {SR[W-2:0],1'b0}.
//    - Each edge decrements count.
//    - At the edge where count==0: state <= DONE.
//    - Exactly WIDTH bits are emitted on consecutive cycles.
//  - DONE (one cycle):
//    - done=1, done_id=winner, gnt still asserted, so_valid=0, SO=0.
//    - At the next edge: last <= winner, gnt <= 0, state <= IDLE.
//  - Latency: grant edge E; bits valid in cycles E+1 through E+WIDTH; done in cycle E+WIDTH+1.
//    - Earliest next grant edge is E+WIDTH+2, a 1-cycle IDLE gap.
//  - req changes during SHIFT or DONE are ignored. A transfer cannot be aborted except by rst.
//  - A requester lowers req on seeing done. If req is still high in IDLE, it counts as a new request.
//  - Fairness: with both requesting continuously, grants alternate 0,1,0,1... Neither requester waits more than one transfer.
//  - rst mid-transfer: the partial word is discarded, no done pulse is issued, and last returns to 1.
//  - gnt is never 2'b11. busy = (state != IDLE).
// TESTING
//  - Reset: rst=1 at any time.
//    -> gnt=0, SO=0, so_valid=0, done=0, busy=0 immediately, without a clock edge.
//  - Single transfer, WIDTH=5, MSB_1ST=0: req=01, data0=5'b10110.
//    -> SO = 0,1,1,0,1 on 5 valid cycles; done=1, done_id=0 on the 6th cycle.
//  - MSB-first, WIDTH=5, MSB_1ST=1: req=10, data1=5'b10011.
//    -> SO = 1,0,0,1,1; done_id=1.
//  - Contention: req=11 held for 3 transfers after reset.
//    -> grant order 0,1,0; each done is followed by 1 IDLE cycle.
//  - Data/req glitch: change data0 and drop req during SHIFT.
//    -> transmitted bits match the word sampled at grant; done is still pulsed.
//  - Reset mid-transfer: assert rst at bit 3.
//    -> no done pulse; after release, req=11 grants requester 0.

Source files
------------

// File: rtl/sr_share_ctrl.sv
// Two-requester front end for one serial-out shift register: round-robin grant,
// parallel load, WIDTH-bit serial shift, then a one-cycle done pulse.
module sr_share_ctrl #(
    parameter int unsigned WIDTH   = 5,
    parameter bit          MSB_1ST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             SO,
    output logic             so_valid,
    output logic             done,
    output logic             done_id
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    count;
    logic             last;
    logic             win;

    logic             win_c;
    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] sr_shift_c;
    logic             first_bit_c;
    logic             next_bit_c;

    // Arbitration, load word selection and shift datapath
    always_comb begin
        win_c       = (req == 2'b11) ? ~last : req[1];
        word_c      = win_c ? data1 : data0;
        sr_shift_c  = MSB_1ST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        first_bit_c = MSB_1ST ? word_c[WIDTH-1] : word_c[0];
        next_bit_c  = MSB_1ST ? sr[WIDTH-2] : sr[1];
    end

    // SO is registered one bit ahead so it always matches the bit the SR exposes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            count    <= '0;
            last     <= 1'b1;
            win      <= 1'b0;
            gnt      <= 2'b00;
            busy     <= 1'b0;
            SO       <= 1'b0;
            so_valid <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        sr       <= word_c;
                        win      <= win_c;
                        gnt      <= win_c ? 2'b10 : 2'b01;
                        count    <= CW'(WIDTH - 1);
                        busy     <= 1'b1;
                        so_valid <= 1'b1;
                        SO       <= first_bit_c;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr    <= sr_shift_c;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        so_valid <= 1'b0;
                        SO       <= 1'b0;
                        done     <= 1'b1;
                        done_id  <= win;
                        state    <= DONE;
                    end else begin
                        SO <= next_bit_c;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    done_id <= 1'b0;
                    last    <= win;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_share_ctrl.sv
// Scoreboard bench for sr_share_ctrl: one LSB-first and one MSB-first instance
// share stimulus; a transaction-level model predicts bits, grants and done ids.
module tb_sr_share_ctrl;

    localparam int unsigned WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;

    logic [1:0] gnt_o   [2];
    logic       busy_o  [2];
    logic       so_o    [2];
    logic       valid_o [2];
    logic       done_o  [2];
    logic       id_o    [2];

    int n_cmp = 0;
    int n_bad = 0;

    sr_share_ctrl #(.WIDTH(WIDTH), .MSB_1ST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt_o[0]), .busy(busy_o[0]), .SO(so_o[0]), .so_valid(valid_o[0]),
        .done(done_o[0]), .done_id(id_o[0])
    );

    sr_share_ctrl #(.WIDTH(WIDTH), .MSB_1ST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt_o[1]), .busy(busy_o[1]), .SO(so_o[1]), .so_valid(valid_o[1]),
        .done(done_o[1]), .done_id(id_o[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: a transfer occupies WIDTH+1 cycles after its grant edge
    bit   qb0 [$];
    bit   qb1 [$];
    int   qid0 [$];
    int   qid1 [$];
    int   rem;
    int   last_w;
    logic [1:0] exp_gnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem = 0;
            last_w = 1;
            exp_gnt = 2'b00;
            qb0.delete();
            qb1.delete();
            qid0.delete();
            qid1.delete();
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) exp_gnt = 2'b00;
        end else if (req != 2'b00) begin
            int w;
            logic [WIDTH-1:0] word;
            w = (req == 2'b11) ? 1 - last_w : ((req == 2'b10) ? 1 : 0);
            word = (w == 1) ? data1 : data0;
            for (int k = 0; k < int'(WIDTH); k++) begin
                qb0.push_back(word[k]);
                qb1.push_back(word[int'(WIDTH) - 1 - k]);
            end
            qid0.push_back(w);
            qid1.push_back(w);
            last_w = w;
            rem = WIDTH + 1;
            exp_gnt = (w == 1) ? 2'b10 : 2'b01;
        end
    end

    // Monitor: sample on the falling edge, pop the scoreboard when the DUT presents data
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                bit eb;
                int eid;
                check("gnt", int'(gnt_o[d]), int'(exp_gnt));
                check("busy", int'(busy_o[d]), int'(rem > 0));
                check("so_valid", int'(valid_o[d]), int'(rem > 1));
                check("done", int'(done_o[d]), int'(rem == 1));
                if (valid_o[d]) begin
                    if ((d == 0 ? qb0.size() : qb1.size()) == 0) begin
                        check("bit_queue_empty", 1, 0);
                    end else begin
                        eb = (d == 0) ? qb0.pop_front() : qb1.pop_front();
                        check(d == 0 ? "so_lsb" : "so_msb", int'(so_o[d]), int'(eb));
                    end
                end else begin
                    check("so_idle", int'(so_o[d]), 0);
                end
                if (done_o[d]) begin
                    if ((d == 0 ? qid0.size() : qid1.size()) == 0) begin
                        check("id_queue_empty", 1, 0);
                    end else begin
                        eid = (d == 0) ? qid0.pop_front() : qid1.pop_front();
                        check("done_id", int'(id_o[d]), eid);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            check({nm, "_gnt"}, int'(gnt_o[d]), 0);
            check({nm, "_so"}, int'(so_o[d]), 0);
            check({nm, "_valid"}, int'(valid_o[d]), 0);
            check({nm, "_done"}, int'(done_o[d]), 0);
            check({nm, "_busy"}, int'(busy_o[d]), 0);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 2'b00;
        data0 = '0;
        data1 = '0;
        #3;
        check_all_zero("reset");
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // Single transfers, both bit orders
        data0 = 5'b10110;
        data1 = 5'b10011;
        req = 2'b01;
        cyc(1);
        req = 2'b00;
        cyc(8);
        req = 2'b10;
        cyc(1);
        req = 2'b00;
        cyc(8);

        // Contention right after reset: 0,1,0
        pulse_reset();
        req = 2'b11;
        cyc(3 * (WIDTH + 2));
        req = 2'b00;
        cyc(8);

        // Data and req change mid-shift
        data0 = 5'b01101;
        req = 2'b01;
        cyc(3);
        data0 = ~data0;
        req = 2'b00;
        cyc(8);

        // Asynchronous reset in the middle of a transfer
        data0 = 5'($urandom);
        req = 2'b01;
        cyc(1);
        req = 2'b00;
        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        cyc(1);
        rst = 1'b0;
        req = 2'b11;
        cyc(1);
        check("post_reset_gnt", int'(gnt_o[0]), 1);
        req = 2'b00;
        cyc(8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req   = 2'($urandom_range(0, 3));
            data0 = 5'($urandom);
            data1 = 5'($urandom);
            cyc(1);
        end
        req = 2'b00;
        cyc(WIDTH + 4);

        check("bits_left_lsb", qb0.size(), 0);
        check("bits_left_msb", qb1.size(), 0);
        check("ids_left_lsb", qid0.size(), 0);
        check("ids_left_msb", qid1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
